// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: read-style encodings and the population-width helper
// used by both the single-clock and mixed-clock FIFOs.
package fifo_pkg;

  localparam int FIFO_MODE_FWFT = 0;
  localparam int FIFO_MODE_REG  = 1;

  // Bits needed to count 0..cap inclusive.
  function automatic int fifo_pop_width(input int cap);
    return $clog2(cap + 1);
  endfunction

endpackage

// File: rtl/fifo_storage_array.sv
// FIFO word storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module fifo_storage_array #(
  parameter  int CAPACITY  = 5,
  parameter  int BIT_WIDTH = 16,
  localparam int AW        = (CAPACITY > 1) ? $clog2(CAPACITY) : 1
) (
  input  logic                 clock,
  input  logic                 i_wr_en,
  input  logic [AW-1:0]        i_wr_addr,
  input  logic [BIT_WIDTH-1:0] i_wr_data,
  input  logic [AW-1:0]        i_rd_addr,
  output logic [BIT_WIDTH-1:0] o_rd_data
);

  logic [BIT_WIDTH-1:0] r_mem [CAPACITY];

  always_ff @(posedge clock) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/flagged_sync_fifo.sv
// Single-clock FIFO with arbitrary depth, population count, threshold flags
// and sticky overflow/underflow; read side is either fall-through or registered.
module flagged_sync_fifo import fifo_pkg::*; #(
  parameter  int CAPACITY           = 5,
  parameter  int BIT_WIDTH          = 16,
  parameter  int OUTPUT_MODE        = FIFO_MODE_FWFT,
  parameter  int ALMOST_FULL_LEVEL  = CAPACITY - 1,
  parameter  int ALMOST_EMPTY_LEVEL = 1,
  localparam int PW                 = fifo_pop_width(CAPACITY)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [BIT_WIDTH-1:0] data_in,
  input  logic                 enqueue,
  input  logic                 dequeue,
  input  logic                 flush,
  output logic [BIT_WIDTH-1:0] data_out,
  output logic [PW-1:0]        population,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int AW = (CAPACITY > 1) ? $clog2(CAPACITY) : 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(CAPACITY - 1);

  logic [AW-1:0]        r_rd_ptr, r_wr_ptr;
  logic [PW-1:0]        r_population;
  logic                 r_overflow, r_underflow;
  logic                 w_deq_acc, w_enq_acc;
  logic [BIT_WIDTH-1:0] w_rd_data;

  assign full         = (r_population == PW'(CAPACITY));
  assign empty        = (r_population == '0);
  assign almost_full  = (int'(r_population) >= ALMOST_FULL_LEVEL);
  assign almost_empty = (int'(r_population) <= ALMOST_EMPTY_LEVEL);
  assign population   = r_population;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

  // A dequeue in the same cycle frees the slot, so a full FIFO can still accept.
  assign w_deq_acc = dequeue & ~flush & ~empty;
  assign w_enq_acc = enqueue & ~flush & (~full | w_deq_acc);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_population <= '0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else if (flush) begin
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_population <= '0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      if (w_deq_acc) r_rd_ptr <= (r_rd_ptr == LAST_IDX) ? '0 : r_rd_ptr + 1'b1;
      if (w_enq_acc) r_wr_ptr <= (r_wr_ptr == LAST_IDX) ? '0 : r_wr_ptr + 1'b1;
      if (w_enq_acc && !w_deq_acc)      r_population <= r_population + 1'b1;
      else if (w_deq_acc && !w_enq_acc) r_population <= r_population - 1'b1;
      if (enqueue && !w_enq_acc) r_overflow  <= 1'b1;
      if (dequeue && empty)      r_underflow <= 1'b1;
    end
  end

  fifo_storage_array #(
    .CAPACITY  (CAPACITY),
    .BIT_WIDTH (BIT_WIDTH)
  ) u_storage (
    .clock     (clock),
    .i_wr_en   (w_enq_acc),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (data_in),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  generate
    if (OUTPUT_MODE == FIFO_MODE_REG) begin : g_reg_out
      logic [BIT_WIDTH-1:0] r_data_out;
      // Holds the last dequeued word; flush leaves it alone.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)       r_data_out <= '0;
        else if (w_deq_acc) r_data_out <= w_rd_data;
      end
      assign data_out = r_data_out;
    end else begin : g_fwft_out
      assign data_out = w_rd_data;
    end
  endgenerate

endmodule

// File: tb/tb_flagged_sync_fifo.sv
// Self-checking bench: fall-through and registered-output FIFOs driven by the
// same stimulus and compared against a queue-based reference model.
module tb_flagged_sync_fifo;

  localparam int CAP = 5;
  localparam int BW  = 16;
  localparam int PW  = 3;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [BW-1:0] data_in;
  logic          enqueue, dequeue, flush;

  logic [BW-1:0] dout0, dout1;
  logic [PW-1:0] pop0, pop1;
  logic          full0, empty0, af0, ae0, ovf0, unf0;
  logic          full1, empty1, af1, ae1, ovf1, unf1;

  int n_cmp  = 0;
  int n_fail = 0;

  // reference model
  logic [BW-1:0] q[$];
  logic          m_ovf, m_unf;
  logic [BW-1:0] m_dreg;

  always #5 clock = ~clock;

  flagged_sync_fifo #(.CAPACITY(CAP), .BIT_WIDTH(BW), .OUTPUT_MODE(0)) u0 (
    .clock(clock), .reset_n(reset_n), .data_in(data_in), .enqueue(enqueue),
    .dequeue(dequeue), .flush(flush), .data_out(dout0), .population(pop0),
    .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
    .overflow(ovf0), .underflow(unf0));

  flagged_sync_fifo #(.CAPACITY(CAP), .BIT_WIDTH(BW), .OUTPUT_MODE(1)) u1 (
    .clock(clock), .reset_n(reset_n), .data_in(data_in), .enqueue(enqueue),
    .dequeue(dequeue), .flush(flush), .data_out(dout1), .population(pop1),
    .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
    .overflow(ovf1), .underflow(unf1));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
    m_dreg = '0;
  endtask

  task automatic model_step(input logic e, input logic d, input logic f, input logic [BW-1:0] din);
    bit dacc, eacc;
    if (f) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      dacc = d && (q.size() > 0);
      eacc = e && ((q.size() < CAP) || dacc);
      if (e && !eacc) m_ovf = 1'b1;
      if (d && q.size() == 0) m_unf = 1'b1;
      if (dacc) begin
        m_dreg = q[0];
        void'(q.pop_front());
      end
      if (eacc) q.push_back(din);
    end
  endtask

  task automatic check_model(input string tag);
    int n;
    n = q.size();
    chk({tag, "_pop0"},  32'(pop0), n);
    chk({tag, "_pop1"},  32'(pop1), n);
    chk({tag, "_full"},  32'(full0),  32'(n == CAP));
    chk({tag, "_empty"}, 32'(empty0), 32'(n == 0));
    chk({tag, "_af"},    32'(af0),    32'(n >= CAP - 1));
    chk({tag, "_ae"},    32'(ae0),    32'(n <= 1));
    chk({tag, "_ovf"},   32'(ovf1),   32'(m_ovf));
    chk({tag, "_unf"},   32'(unf1),   32'(m_unf));
    chk({tag, "_dreg"},  32'(dout1),  32'(m_dreg));
    if (n > 0) chk({tag, "_front"}, 32'(dout0), 32'(q[0]));
  endtask

  // Drive at the falling edge, let one rising edge pass, check at the next falling edge.
  task automatic cycle(input logic e, input logic d, input logic f, input logic [BW-1:0] din, input string tag);
    enqueue = e; dequeue = d; flush = f; data_in = din;
    model_step(e, d, f, din);
    @(posedge clock);
    @(negedge clock);
    check_model(tag);
  endtask

  typedef struct {
    logic          e, d, f;
    logic [BW-1:0] din;
    int            pop;
    logic          full, af, ovf, unf;
    logic [BW-1:0] front;
    logic [BW-1:0] dreg;
  } vec_t;

  vec_t tbl[11];

  initial begin
    // e  d  f  din     pop full af ovf unf front  dreg
    tbl[0]  = '{1, 0, 0, 10000, 1, 0, 0, 0, 0, 10000, 0};
    tbl[1]  = '{1, 0, 0, 20000, 2, 0, 0, 0, 0, 10000, 0};
    tbl[2]  = '{1, 0, 0, 30000, 3, 0, 0, 0, 0, 10000, 0};
    tbl[3]  = '{1, 0, 0, 40000, 4, 0, 1, 0, 0, 10000, 0};
    tbl[4]  = '{1, 0, 0, 50000, 5, 1, 1, 0, 0, 10000, 0};
    tbl[5]  = '{1, 0, 0, 60000, 5, 1, 1, 1, 0, 10000, 0};
    tbl[6]  = '{1, 1, 0, 7,     5, 1, 1, 1, 0, 20000, 10000};
    tbl[7]  = '{1, 0, 1, 999,   0, 0, 0, 0, 0, 0,     10000};
    tbl[8]  = '{1, 0, 0, 500,   1, 0, 0, 0, 0, 500,   10000};
    tbl[9]  = '{0, 1, 0, 0,     0, 0, 0, 0, 0, 0,     500};
    tbl[10] = '{0, 1, 0, 0,     0, 0, 0, 0, 1, 0,     500};

    reset_n = 1'b0; enqueue = 0; dequeue = 0; flush = 0; data_in = '0;
    model_reset();
    repeat (2) @(negedge clock);
    check_model("reset");
    chk("reset_full1", 32'(full1), 0);
    chk("reset_empty1", 32'(empty1), 1);
    reset_n = 1'b1;

    // fill, overflow, pass-through while full, flush, refill, underflow
    for (int i = 0; i < 11; i++) begin
      cycle(tbl[i].e, tbl[i].d, tbl[i].f, tbl[i].din, "tbl");
      chk("tbl_pop",  32'(pop0), tbl[i].pop);
      chk("tbl_full", 32'(full0), 32'(tbl[i].full));
      chk("tbl_af",   32'(af0),   32'(tbl[i].af));
      chk("tbl_ovf",  32'(ovf0),  32'(tbl[i].ovf));
      chk("tbl_unf",  32'(unf0),  32'(tbl[i].unf));
      chk("tbl_dreg", 32'(dout1), 32'(tbl[i].dreg));
      if (tbl[i].pop > 0) chk("tbl_front", 32'(dout0), 32'(tbl[i].front));
    end

    // drain and wrap: population 2, then 12 alternating enqueue/dequeue cycles
    cycle(0, 0, 1, 0, "wrap_flush");
    cycle(1, 0, 0, 16'd1, "wrap_pre");
    cycle(1, 0, 0, 16'd2, "wrap_pre");
    for (int i = 0; i < 12; i++) begin
      if (i % 2 == 0) cycle(1, 0, 0, 16'(100 + i), "wrap_enq");
      else            cycle(0, 1, 0, 16'(0), "wrap_deq");
    end
    while (q.size() > 0) cycle(0, 1, 0, 0, "wrap_drain");
    cycle(0, 1, 0, 0, "wrap_under");
    chk("wrap_underflow", 32'(unf0), 1);

    // registered output lags dequeue by one edge and holds in between
    cycle(0, 0, 1, 0, "mode_flush");
    cycle(1, 0, 0, 16'd111, "mode_w");
    cycle(1, 0, 0, 16'd222, "mode_w");
    cycle(0, 1, 0, 0, "mode_d");
    chk("mode_lag1", 32'(dout1), 111);
    chk("mode_fwft_next", 32'(dout0), 222);
    cycle(0, 0, 0, 0, "mode_idle");
    chk("mode_hold", 32'(dout1), 111);
    cycle(0, 1, 0, 0, "mode_d");
    chk("mode_lag2", 32'(dout1), 222);

    // empty with both requests: enqueue accepted, dequeue rejected, no bypass
    cycle(0, 0, 1, 0, "both_flush");
    cycle(1, 1, 0, 16'd4242, "both_empty");
    chk("both_empty_dreg", 32'(dout1), 222);
    chk("both_empty_unf", 32'(unf0), 1);

    // async reset between edges with flags set
    for (int i = 0; i < 6; i++) cycle(1, 0, 0, 16'(900 + i), "pre_rst");
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    chk("arst_pop",   32'(pop1), 0);
    chk("arst_empty", 32'(empty1), 1);
    chk("arst_full",  32'(full1), 0);
    chk("arst_ovf",   32'(ovf0), 0);
    chk("arst_unf",   32'(unf0), 0);
    chk("arst_dreg",  32'(dout1), 0);
    @(negedge clock);
    reset_n = 1'b1;
    check_model("arst_rel");

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      cycle(logic'($urandom_range(0, 99) < 55), logic'($urandom_range(0, 99) < 45),
            logic'($urandom_range(0, 39) == 0), 16'($urandom), "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/flagged_sync_fifo.md
FLAGGED_SYNC_FIFO -- requirements
Module: flagged_sync_fifo

Interface
REQ-001 SHALL have parameter CAPACITY, default 5, number of storage entries; legal range 2..1024; need not be a power of two.
REQ-002 SHALL have parameter BIT_WIDTH, default 16, width of each data word.
REQ-003 SHALL have parameter OUTPUT_MODE, default 0, read style: 0 = first-word-fall-through, 1 = registered output.
REQ-004 SHALL have parameter ALMOST_FULL_LEVEL, default CAPACITY-1, population at or above which almost_full asserts.
REQ-005 SHALL have parameter ALMOST_EMPTY_LEVEL, default 1, population at or below which almost_empty asserts.
REQ-006 SHALL define local PW = $clog2(CAPACITY+1), the population width.
REQ-007 SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-008 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have the following ports:
- data_out, output, BIT_WIDTH, read data.
- population, output, PW, current entry count.
- full, output, 1, population == CAPACITY.
- empty, output, 1, population == 0.
- almost_full, output, 1, threshold flag.
- almost_empty, output, 1, threshold flag.
- overflow, output, 1, sticky flag: rejected enqueue.
- underflow, output, 1, sticky flag: rejected dequeue.
- data_in, input, BIT_WIDTH, write data.
- enqueue, input, 1, write request.
- dequeue, input, 1, read request.
- flush, input, 1, synchronous clear.

Function
REQ-010 SHALL accept a dequeue iff dequeue=1, flush=0 and empty=0.
REQ-011 SHALL accept an enqueue iff enqueue=1, flush=0, and either full=0 or a dequeue is accepted in the same cycle.
REQ-012 SHALL update population per edge: +1 for enqueue only, -1 for dequeue only, unchanged when both or neither are accepted.
REQ-013 SHALL write data_in at write_ptr on an accepted enqueue, and advance each pointer modulo CAPACITY on its accepted operation (CAPACITY-1 wraps to 0).
REQ-014 SHALL, when full and both enqueue and dequeue are accepted, retain the full state and return the oldest word.
REQ-015 SHALL, when empty and both requests arrive, accept the enqueue, reject the dequeue, and set underflow; empty data SHALL NOT bypass to the output.
REQ-016 SHALL, in OUTPUT_MODE 0, drive data_out combinationally from buffer[read_ptr]; the value is valid only while empty=0.
REQ-017 SHALL, in OUTPUT_MODE 1, load data_out with buffer[read_ptr] on the edge of an accepted dequeue (1-cycle latency) and hold it otherwise.
REQ-018 SHALL, on flush=1, set population, read_ptr and write_ptr to 0 and clear overflow and underflow, ignoring enqueue/dequeue that cycle; flush SHALL NOT clear buffer contents or the OUTPUT_MODE 1 data_out.
REQ-019 SHALL set overflow on enqueue=1 that is not accepted with flush=0, and set underflow on dequeue=1 with empty=1 and flush=0; both flags stay set until flush or reset.
REQ-020 SHALL derive full, empty, almost_full and almost_empty combinationally from the registered population, with no extra latency.

Reset
REQ-021 SHALL, while reset_n=0, asynchronously force the following, independent of clock:
- population, read_ptr, write_ptr, overflow, underflow and registered data_out to 0;
- empty=1 and full=0.
REQ-022 SHALL leave buffer contents unreset.
REQ-023 SHALL treat reset assertion mid-operation as discarding all queued entries.

Structure
REQ-024 SHALL take OUTPUT_MODE encodings (FIFO_MODE_FWFT=0, FIFO_MODE_REG=1) from shared package fifo_pkg, together with a population-width helper reused by the mixed-clock FIFO.
REQ-025 SHALL place storage in one sub-module fifo_storage_array (parameters CAPACITY, BIT_WIDTH: one synchronous write port, one asynchronous read port, no reset).
REQ-026 SHALL keep pointer, population and flag logic in flagged_sync_fifo, with no other sub-modules.

Verification (CAPACITY=5, BIT_WIDTH=16)
REQ-027 Fill: enqueue 10000..50000 in 5 cycles -> population 1..5; full=1 and almost_full=1 at 5; almost_full=1 already at 4; no overflow.
REQ-028 Overflow and pass-through:
- enqueue 60000 while full -> overflow=1, population 5, 60000 not stored.
- enqueue+dequeue together while full -> data 10000 returned, population stays 5.
REQ-029 Drain and wrap: 12 alternating enqueue/dequeue cycles from population 2 -> FIFO order preserved across pointer wrap 4->0; extra dequeue when empty -> underflow=1.
REQ-030 Flush: flush with enqueue=1 from population 5 -> population 0, empty=1, flags cleared, enqueue ignored; next enqueue 500 -> population 1 and 500 read first.
REQ-031 Modes: same stream with OUTPUT_MODE 0 vs 1 -> mode 1 data_out lags the accepted dequeue by exactly one clock and holds between dequeues.
REQ-032 Async reset: reset_n low mid-stream between edges -> outputs at reset values immediately; after release, population 0 and empty=1.
